// File: rtl/shift_pin_sin_rx.sv
// Serial-in byte receiver for the Pi-to-TI path: pin sync, MSB-first shift, valid/ready hold.
// Optional SCLK glitch filter with SHIFT_PIN_SIN_FILTER_EN.
module shift_pin_sin_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             C,
  input  logic             RST_N,
  input  logic             SCLK,
  input  logic             SDATA,
  input  logic             SLATCH,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             OVERRUN,
  input  logic             OVR_CLR,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
`ifdef SHIFT_PIN_SIN_FILTER_EN
  localparam int GUARD = SYNC_STAGES + 2;
`else
  localparam int GUARD = SYNC_STAGES + 1;
`endif
  localparam int GW = $clog2(GUARD + 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic [SYNC_STAGES-1:0] slatch_sync;
  logic                   sclk_s;
  logic                   sdata_s;
  logic                   slatch_s;
  logic                   sclk_lvl;
  logic                   sdata_lvl;
  logic                   slatch_lvl;
  logic                   sclk_q;
  logic                   slatch_q;
  logic [GW-1:0]          gcnt;
  logic                   guard_on;
  logic                   sclk_rise;
  logic                   slatch_rise;

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] dout_n;
  logic             dvalid_n;
  logic             ovr_n;
  logic [WIDTH-1:0] byte_c;
  logic             done;

  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync   <= '0;
      sdata_sync  <= '0;
      slatch_sync <= '0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      sdata_sync  <= {sdata_sync[SYNC_STAGES-2:0], SDATA};
      slatch_sync <= {slatch_sync[SYNC_STAGES-2:0], SLATCH};
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign sdata_s  = sdata_sync[SYNC_STAGES-1];
  assign slatch_s = slatch_sync[SYNC_STAGES-1];

`ifdef SHIFT_PIN_SIN_FILTER_EN
  logic sclk_p;
  logic sdata_d;
  logic slatch_d;

  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      sclk_p   <= 1'b0;
      sdata_d  <= 1'b0;
      slatch_d <= 1'b0;
    end else begin
      sclk_p   <= sclk_s;
      sdata_d  <= sdata_s;
      slatch_d <= slatch_s;
    end
  end

  // level moves only when two successive samples agree; sclk_q is the held level
  assign sclk_lvl   = (sclk_s == sclk_p) ? sclk_s : sclk_q;
  assign sdata_lvl  = sdata_d;
  assign slatch_lvl = slatch_d;
`else
  assign sclk_lvl   = sclk_s;
  assign sdata_lvl  = sdata_s;
  assign slatch_lvl = slatch_s;
`endif

  assign guard_on    = (gcnt != GW'(GUARD));
  assign sclk_rise   = sclk_lvl & ~sclk_q & ~guard_on;
  assign slatch_rise = slatch_lvl & ~slatch_q & ~guard_on;

  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      sclk_q   <= 1'b0;
      slatch_q <= 1'b0;
      gcnt     <= '0;
    end else begin
      sclk_q   <= sclk_lvl;
      slatch_q <= slatch_lvl;
      if (guard_on) gcnt <= gcnt + GW'(1);
    end
  end

  assign byte_c = {shift_r[WIDTH-2:0], sdata_lvl};

  always_comb begin
    shift_n  = shift_r;
    cnt_n    = cnt;
    dout_n   = DOUT;
    dvalid_n = DVALID;
    ovr_n    = OVERRUN;
    done     = 1'b0;
    if (slatch_rise) begin
      cnt_n   = '0;
      shift_n = '0;
    end else if (sclk_rise) begin
      if (cnt == CW'(WIDTH - 1)) begin
        done    = 1'b1;
        cnt_n   = '0;
        shift_n = '0;
      end else begin
        shift_n = byte_c;
        cnt_n   = cnt + CW'(1);
      end
    end
    if (OVR_CLR) ovr_n = 1'b0;
    // a full holding register drops the new byte unless it is drained this cycle
    if (done) begin
      if (!DVALID || DREADY) begin
        dout_n   = byte_c;
        dvalid_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end else if (DVALID && DREADY) begin
      dvalid_n = 1'b0;
    end
  end

  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      shift_r <= '0;
      cnt     <= '0;
      DOUT    <= '0;
      DVALID  <= 1'b0;
      OVERRUN <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      shift_r <= shift_n;
      cnt     <= cnt_n;
      DOUT    <= dout_n;
      DVALID  <= dvalid_n;
      OVERRUN <= ovr_n;
      BUSY    <= (cnt_n != '0);
    end
  end

endmodule
